// File: rtl/dot_product_datapath_pkg.sv
// dot_pkg: shared constants and element/accumulator types for the
// dot-product datapath slice.
//   DEF_DATA_W : default signed element width
//   DEF_LEN_W  : default vector-length width
//   DEF_ACC_W  : default signed accumulator width (>= 2*DEF_DATA_W)
//   elem_t / prod_t / acc_t / len_t : typed views at the default widths
package dot_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_ACC_W  = 40;

    typedef logic signed [DEF_DATA_W-1:0]   elem_t;
    typedef logic signed [2*DEF_DATA_W-1:0] prod_t;
    typedef logic signed [DEF_ACC_W-1:0]    acc_t;
    typedef logic        [DEF_LEN_W-1:0]    len_t;

endpackage

// File: rtl/dot_product_datapath_mac_unit.sv
// mac_unit: stage-1 registered signed multiplier and stage-2 accumulator.
// Optional macro DOT_SATURATE_EN: saturating accumulate with sticky ovf;
// without it the accumulate wraps and ovf is tied low.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop pipeline, zero accumulator and ovf
//   accept     : capture a_data*b_data into the product register
//   tag        : accumulate this product when it reaches stage 2
//   a_data, b_data : signed elements
//   prod_vld   : product register holds an unconsumed product
//   acc        : running signed accumulator
//   ovf        : sticky saturation flag
module mac_unit
    import dot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     accept,
    input  logic                     tag,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     prod_vld,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    mult;
    logic signed [PW-1:0]    prod;
    logic                    prod_tag;
    logic signed [ACC_W-1:0] acc_next;

    assign mult = PW'(a_data) * PW'(b_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            prod_tag <= 1'b0;
        end else if (clear) begin
            prod_vld <= 1'b0;
        end else if (accept) begin
            prod     <= mult;
            prod_vld <= 1'b1;
            prod_tag <= tag;
        end else begin
            prod_vld <= 1'b0;
        end
    end

`ifdef DOT_SATURATE_EN
    // One guard bit: overflow when the two top bits of the widened sum differ;
    // the guard bit then carries the true sign and picks the clamp direction.
    logic signed [ACC_W:0] sum_w;
    logic                  clamp;
    logic                  ovf_q;

    always_comb begin
        sum_w = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
        clamp = sum_w[ACC_W] != sum_w[ACC_W-1];
        if (!clamp)
            acc_next = sum_w[ACC_W-1:0];
        else if (sum_w[ACC_W])
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        else
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            ovf_q <= 1'b0;
        else if (prod_vld && prod_tag && clamp)
            ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign acc_next = acc + ACC_W'(prod);
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (prod_vld && prod_tag)
            acc <= acc_next;
    end

endmodule

// File: rtl/dot_product_datapath.sv
// dot_product_datapath: element counter, armed flag and zi generation around
// a two-stage multiply-accumulate unit.
// Optional macro DOT_SATURATE_EN: saturating accumulate with sticky ovf.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   ldi        : load counter from vec_len, clear accumulator and pipeline
//   vec_len    : number of element pairs to process
//   compute    : accept one element pair this cycle
//   en_sum     : accumulate the accepted pair
//   a_data, b_data : signed elements
//   zi         : counter exhausted and pipeline drained
//   sum        : signed accumulator value
//   ovf        : sticky saturation flag
module dot_product_datapath
    import dot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ldi,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic                     compute,
    input  logic                     en_sum,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     zi,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    logic [LEN_W-1:0] cnt;
    logic             armed;
    logic             accept;
    logic             prod_vld;

    assign accept = !ldi && compute && (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (ldi) begin
            cnt   <= vec_len;
            armed <= 1'b1;
        end else if (accept) begin
            cnt   <= cnt - LEN_W'(1);
        end
    end

    // armed keeps zi low after reset until a vector has actually been loaded.
    assign zi = armed && (cnt == '0) && !prod_vld;

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (ldi),
        .accept   (accept),
        .tag      (en_sum),
        .a_data   (a_data),
        .b_data   (b_data),
        .prod_vld (prod_vld),
        .acc      (sum),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_dot_product_datapath.sv
// Directed bench for dot_product_datapath (ACC_W=32 so the saturation
// boundary is reachable with 16-bit operands).
module tb_dot_product_datapath;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     ldi;
    logic [LEN_W-1:0]         vec_len;
    logic                     compute;
    logic                     en_sum;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;
    logic                     zi;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf;

    int checks   = 0;
    int failures = 0;

    dot_product_datapath #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ldi     (ldi),
        .vec_len (vec_len),
        .compute (compute),
        .en_sum  (en_sum),
        .a_data  (a_data),
        .b_data  (b_data),
        .zi      (zi),
        .sum     (sum),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pair(input int a, input int b, input logic tag);
        compute = 1'b1;
        en_sum  = tag;
        a_data  = DATA_W'(a);
        b_data  = DATA_W'(b);
        tick();
    endtask

    task automatic load(input int n);
        compute = 1'b0;
        ldi     = 1'b1;
        vec_len = LEN_W'(n);
        tick();
        ldi     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ldi = 1'b0; vec_len = '0; compute = 1'b0;
        en_sum = 1'b0; a_data = '0; b_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_zi", zi, 0);
        check("rst_sum", sum, 0);
        check("rst_ovf", ovf, 0);
        tick();
        check("idle_zi_unarmed", zi, 0);

        // Back-to-back vector of 4
        load(4);
        check("ld4_zi", zi, 0);
        pair(1, 2, 1'b1);
        pair(3, 4, 1'b1);
        check("v4_latency_sum", sum, 2);
        pair(-5, 6, 1'b1);
        pair(7, -8, 1'b1);
        check("v4_zi_draining", zi, 0);
        check("v4_sum_partial", sum, -16);
        compute = 1'b0;
        tick();
        check("v4_zi", zi, 1);
        check("v4_sum", sum, -72);
        tick();
        check("v4_sum_stable", sum, -72);

        // Gapped vector of 3
        load(3);
        for (int j = 0; j < 3; j++) begin
            pair(10, 10, 1'b1);
            check("gap_zi_accept", zi, 0);
            compute = 1'b0;
            tick();
            check("gap_sum", sum, 100 * (j + 1));
            check("gap_zi", zi, (j == 2) ? 1 : 0);
            tick();
        end
        check("gap_sum_final", sum, 300);

        // Zero-length vector
        load(0);
        check("len0_zi", zi, 1);
        check("len0_sum", sum, 0);
        pair(9, 9, 1'b1);
        compute = 1'b0;
        tick();
        check("len0_ignored_sum", sum, 0);
        check("len0_ignored_zi", zi, 1);

        // Reset mid-operation
        load(5);
        pair(4, 5, 1'b1);
        pair(4, 5, 1'b1);
        compute = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_zi", zi, 0);
        check("midrst_sum", sum, 0);
        tick();
        check("midrst_zi_hold", zi, 0);
        load(1);
        pair(2, 3, 1'b1);
        check("reload_zi_draining", zi, 0);
        compute = 1'b0;
        tick();
        check("reload_zi", zi, 1);
        check("reload_sum", sum, 6);

        // ldi and compute in the same cycle: the pair is dropped
        ldi = 1'b1; vec_len = LEN_W'(2); compute = 1'b1; en_sum = 1'b1;
        a_data = DATA_W'(9); b_data = DATA_W'(9);
        tick();
        ldi = 1'b0; compute = 1'b0;
        tick();
        check("ldi_cmp_sum", sum, 0);
        check("ldi_cmp_zi", zi, 0);
        pair(1, 1, 1'b1);
        pair(1, 1, 1'b1);
        compute = 1'b0;
        tick();
        check("ldi_cmp_cnt_kept_zi", zi, 1);
        check("ldi_cmp_cnt_kept_sum", sum, 2);

        // en_sum low: product computed and counted but not accumulated
        load(2);
        pair(5, 5, 1'b0);
        pair(2, 2, 1'b1);
        compute = 1'b0;
        tick();
        check("tag_sum", sum, 4);
        check("tag_zi", zi, 1);

        // Accumulator boundary
        load(3);
        pair(-32768, -32768, 1'b1);
        pair(-32768, -32768, 1'b1);
        pair(-32768, -32768, 1'b1);
        compute = 1'b0;
        tick();
        check("big_zi", zi, 1);
`ifdef DOT_SATURATE_EN
        check("sat_sum", sum, 64'sd2147483647);
        check("sat_ovf", ovf, 1);
`else
        check("wrap_sum", sum, -64'sd1073741824);
        check("wrap_ovf", ovf, 0);
`endif
        load(1);
        check("ovf_clear_ovf", ovf, 0);
        check("ovf_clear_sum", sum, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
